// File: rtl/mano_seq_decoder_if.sv
// ---------------------------------------------------------------------------
// mano_seq_decoder_if
// Bundles the control, bus and decode signals of the basic-computer timing
// and decode front end. Clock and reset stay outside as plain ports.
//
// Signals (IR_W = instruction width):
//   start, hlt, sc_clr        : sequencing controls from the control unit
//   bus_in[IR_W-1:0]          : common bus, sampled into IR during fetch
//   ien, fgi, fgo             : interrupt enable and I/O flags
//   T[7:0], D[7:0]            : one-hot timing and opcode vectors
//   I, B[IR_W-5:0]            : indirect bit and address field
//   running, r                : S flip-flop and interrupt-cycle flip-flop R
//
// Modports:
//   master : drives the controls and the bus, observes the decode outputs
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface mano_seq_decoder_if #(
  parameter int IR_W = 16
);
  logic            start;
  logic            hlt;
  logic            sc_clr;
  logic [IR_W-1:0] bus_in;
  logic            ien;
  logic            fgi;
  logic            fgo;
  logic [7:0]      T;
  logic [7:0]      D;
  logic            I;
  logic [IR_W-5:0] B;
  logic            running;
  logic            r;

  modport master (
    output start, hlt, sc_clr, bus_in, ien, fgi, fgo,
    input  T, D, I, B, running, r
  );

  modport slave (
    input  start, hlt, sc_clr, bus_in, ien, fgi, fgo,
    output T, D, I, B, running, r
  );
endinterface

// File: rtl/mano_seq_decoder.sv
// ---------------------------------------------------------------------------
// mano_seq_decoder
// Timing and instruction-decode front end of the basic computer. Holds the
// start/stop flip-flop S, the 3-bit sequence counter SC, the instruction
// register IR and the indirect bit I, and produces the one-hot timing
// vector T and the opcode vector D for the downstream control blocks.
//
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mano_seq_decoder_if.slave (controls, bus_in, decode outputs)
//
// Build option:
//   MANO_INTERRUPT_EN : implements the interrupt-cycle flip-flop R. Without
//                       it, r is tied low and ien/fgi/fgo are ignored.
// ---------------------------------------------------------------------------
module mano_seq_decoder #(
  parameter int IR_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  mano_seq_decoder_if.slave bus
);

  logic            s_q, s_d;
  logic [2:0]      sc_q, sc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            i_q, i_d;
  logic [7:0]      tVec;
  logic            rActive;
  logic            irqClr;

  // Timing vector depends only on registers, so it cannot glitch on inputs.
  always_comb begin
    tVec = 8'h00;
    if (s_q) begin
      tVec = 8'h01 << sc_q;
    end
  end

  assign bus.T       = tVec;
  assign bus.D       = 8'h01 << ir_q[IR_W-2 -: 3];
  assign bus.B       = ir_q[IR_W-5:0];
  assign bus.I       = i_q;
  assign bus.running = s_q;

`ifdef MANO_INTERRUPT_EN
  logic r_q, r_d;

  // R is raised outside the fetch phase when an enabled flag is pending,
  // and dropped at the end of T2 of the interrupt cycle.
  always_comb begin
    r_d = r_q;
    if (r_q && tVec[2]) begin
      r_d = 1'b0;
    end else if (s_q && !tVec[0] && !tVec[1] && !tVec[2] &&
                 bus.ien && (bus.fgi || bus.fgo)) begin
      r_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_d;
    end
  end

  assign rActive = r_q;
  assign irqClr  = r_q & tVec[2];
  assign bus.r   = r_q;
`else
  logic unusedIrqInputs;
  assign unusedIrqInputs = bus.ien ^ bus.fgi ^ bus.fgo;
  assign rActive         = 1'b0;
  assign irqClr          = 1'b0;
  assign bus.r           = 1'b0;
`endif

  // Next-state: hlt beats start for S; any clearing condition zeroes SC,
  // otherwise SC counts and wraps naturally from 7 to 0. Fetch loads are
  // suppressed during the interrupt cycle.
  always_comb begin
    s_d  = s_q;
    sc_d = sc_q + 3'd1;
    ir_d = ir_q;
    i_d  = i_q;
    if (bus.hlt) begin
      s_d = 1'b0;
    end else if (bus.start) begin
      s_d = 1'b1;
    end
    if (!s_q || bus.hlt || bus.start || bus.sc_clr || irqClr) begin
      sc_d = 3'd0;
    end
    if (tVec[1] && !rActive) begin
      ir_d = bus.bus_in;
    end
    if (tVec[2] && !rActive) begin
      i_d = ir_q[IR_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 1'b0;
      sc_q <= 3'd0;
      ir_q <= '0;
      i_q  <= 1'b0;
    end else begin
      s_q  <= s_d;
      sc_q <= sc_d;
      ir_q <= ir_d;
      i_q  <= i_d;
    end
  end

endmodule

// File: tb/tb_mano_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_mano_seq_decoder
// Drives directed sequences from the usage scenarios followed by random
// traffic. The driver pushes the expected outputs of each cycle, computed
// from an abstract model of S/SC/IR/I/R, into a queue; the monitor pops and
// compares them mid-cycle.
// ---------------------------------------------------------------------------
module tb_mano_seq_decoder;

  localparam int IR_W = 16;
`ifdef MANO_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]      t;
    logic [7:0]      d;
    logic            i;
    logic [IR_W-5:0] b;
    logic            running;
    logic            r;
  } expect_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  expect_t expQ[$];

  // Abstract model state
  bit              mS;
  int              mSc;
  logic [IR_W-1:0] mIr;
  logic            mI;
  bit              mR;

  mano_seq_decoder_if #(.IR_W(IR_W)) busIf ();

  mano_seq_decoder #(.IR_W(IR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic expect_t modelOutputs();
    expect_t e;
    e.t       = mS ? 8'(1 << mSc) : 8'h00;
    e.d       = 8'(1 << int'(mIr[IR_W-2 -: 3]));
    e.i       = mI;
    e.b       = mIr[IR_W-5:0];
    e.running = mS;
    e.r       = mR;
    return e;
  endfunction

  // One clock edge of the basic computer's sequencing rules.
  task automatic modelStep(input bit st, input bit hl, input bit clr,
                           input logic [IR_W-1:0] bin, input bit ie, input bit fi, input bit fo);
    bit              nS;
    int              nSc;
    logic [IR_W-1:0] nIr;
    logic            nI;
    bit              nR;
    bit              inT0, inT1, inT2;
    inT0 = mS && (mSc == 0);
    inT1 = mS && (mSc == 1);
    inT2 = mS && (mSc == 2);
    nS   = hl ? 1'b0 : (st ? 1'b1 : mS);
    if (!mS || hl || st || clr || (mR && inT2)) nSc = 0;
    else nSc = (mSc + 1) % 8;
    nIr = (inT1 && !mR) ? bin : mIr;
    nI  = (inT2 && !mR) ? mIr[IR_W-1] : mI;
    nR  = mR;
    if (IRQ_EN) begin
      if (mR && inT2) nR = 1'b0;
      else if (mS && !inT0 && !inT1 && !inT2 && ie && (fi || fo)) nR = 1'b1;
    end
    mS = nS; mSc = nSc; mIr = nIr; mI = nI; mR = nR;
  endtask

  task automatic applyStimulus(input bit st, input bit hl, input bit clr,
                               input logic [IR_W-1:0] bin, input bit ie, input bit fi, input bit fo);
    @(negedge clk);
    busIf.start  = st;
    busIf.hlt    = hl;
    busIf.sc_clr = clr;
    busIf.bus_in = bin;
    busIf.ien    = ie;
    busIf.fgi    = fi;
    busIf.fgo    = fo;
    expQ.push_back(modelOutputs());
    modelStep(st, hl, clr, bin, ie, fi, fo);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulses rst_n low between clock edges; the monitor samples while low.
  task automatic resetPulse();
    @(negedge clk);
    busIf.start = 1'b0; busIf.hlt = 1'b0; busIf.sc_clr = 1'b0;
    busIf.bus_in = '0; busIf.ien = 1'b0; busIf.fgi = 1'b0; busIf.fgo = 1'b0;
    rst_n = 1'b0;
    mS = 1'b0; mSc = 0; mIr = '0; mI = 1'b0; mR = 1'b0;
    expQ.push_back(modelOutputs());
    #3;
    rst_n = 1'b1;
  endtask

  // Idles until the next applied cycle is timing state k (bounded).
  task automatic runTo(input int k);
    int n;
    n = 0;
    while (!(mS && mSc == k) && n < 20) begin
      idle();
      n++;
    end
    checks++;
    if (!(mS && mSc == k)) begin
      failures++;
      $display("[TB] FAIL runTo: T%0d not reached within 20 cycles", k);
    end
  endtask

  // Monitor: compares the DUT against the queued expectation every cycle.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("T", 16'(busIf.T), 16'(e.t));
        checkOutput("D", 16'(busIf.D), 16'(e.d));
        checkOutput("I", 16'(busIf.I), 16'(e.i));
        checkOutput("B", 16'(busIf.B), 16'(e.b));
        checkOutput("running", 16'(busIf.running), 16'(e.running));
        checkOutput("r", 16'(busIf.r), 16'(e.r));
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    busIf.start = 1'b0; busIf.hlt = 1'b0; busIf.sc_clr = 1'b0;
    busIf.bus_in = '0; busIf.ien = 1'b0; busIf.fgi = 1'b0; busIf.fgo = 1'b0;
    mS = 1'b0; mSc = 0; mIr = '0; mI = 1'b0; mR = 1'b0;
    repeat (2) @(negedge clk);
    resetPulse();

    $display("[TB] reset and idle");
    repeat (10) idle();

    $display("[TB] fetch/decode A123, then wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hA123, 1'b0, 1'b0, 1'b0);
    repeat (9) idle();

    $display("[TB] sc_clr in T4");
    runTo(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle();

    $display("[TB] hlt with sc_clr in T5, then resume");
    runTo(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    repeat (3) idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h7ABC, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset mid-T3");
    runTo(3);
    resetPulse();
    repeat (4) idle();

    if (IRQ_EN) begin
      $display("[TB] interrupt cycle");
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'hC456, 1'b0, 1'b0, 1'b0);
      runTo(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      runTo(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0);
      repeat (3) idle();
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(299) == 0) begin
        resetPulse();
      end else begin
        applyStimulus($urandom_range(29) == 0, $urandom_range(59) == 0,
                      $urandom_range(5) == 0, 16'($urandom),
                      $urandom_range(3) == 0, $urandom_range(3) == 0,
                      $urandom_range(3) == 0);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
